// File: rtl/idxcnt_pkg.sv
// idxcnt_pkg: shared state encoding and stall counter width for index_counter_2d.
package idxcnt_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int STALL_W = 16;
endpackage

// File: rtl/index_counter_2d_mod_counter.sv
// mod_counter: modulo-MOD up counter with sync clear and terminal-count flag.
module mod_counter #(
    parameter int MOD = 5,
    parameter int W = $clog2(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         tc
);
    assign tc = q == W'(MOD - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else if (clr) q <= '0;
        else if (en) q <= tc ? '0 : q + 1'b1;
endmodule

// File: rtl/index_counter_2d.sv
// index_counter_2d: row-major 2D index scanner with IDLE/RUN/DONE control.
// Optional stall statistics output enabled by macro IDXCNT_STALL_STAT_EN.
module index_counter_2d
    import idxcnt_pkg::*;
#(
    parameter int ROWS = 5,
    parameter int COLS = 5,
    parameter int RW = $clog2(ROWS),
    parameter int CW = $clog2(COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          count_en,
    output logic [RW-1:0] row_idx,
    output logic [CW-1:0] col_idx,
    output logic          valid,
    output logic          row_end,
    output logic          done,
`ifdef IDXCNT_STALL_STAT_EN
    output logic          busy,
    output logic [STALL_W-1:0] stall_cnt
`else
    output logic          busy
`endif
);
    state_t state, state_nx;
    logic run, step, col_tc, row_tc;
    assign run  = state == RUN;
    assign step = run && count_en;
    // Counters sit cleared outside RUN, so every scan starts at (0,0).
    mod_counter #(.MOD(COLS), .W(CW)) u_col (
        .clk(clk), .rst(rst), .clr(!run), .en(step), .q(col_idx), .tc(col_tc)
    );
    mod_counter #(.MOD(ROWS), .W(RW)) u_row (
        .clk(clk), .rst(rst), .clr(!run), .en(step && col_tc), .q(row_idx), .tc(row_tc)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        if (state == IDLE && start) state_nx = RUN;
        if (step && col_tc && row_tc) state_nx = DONE;
        if (state == DONE) state_nx = IDLE;
    end
    assign valid   = run;
    assign row_end = run && col_tc;
    assign done    = state == DONE;
    assign busy    = state != IDLE;
`ifdef IDXCNT_STALL_STAT_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) stall_cnt <= '0;
        else if (state == IDLE && start) stall_cnt <= '0;
        else if (run && !count_en && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_index_counter_2d.sv
// tb_index_counter_2d: randomized and directed checks of index_counter_2d
// against a linear-position reference model (5x5 and 3x7 instances).
module tb_index_counter_2d;
    localparam int RA = 5, CA = 5, RB = 3, CB = 7;
    logic clk = 0, rst = 1;
    logic start = 0, count_en = 0, start_b = 0, count_en_b = 0;
    logic [2:0] row_idx, col_idx;
    logic valid, row_end, done, busy;
    logic [1:0] row_b;
    logic [2:0] col_b;
    logic valid_b, row_end_b, done_b, busy_b;
`ifdef IDXCNT_STALL_STAT_EN
    logic [15:0] stall_cnt, stall_b;
`endif
    int checks = 0, fails = 0;
    int m_st = 0, m_pos = 0, m_stall = 0;
    logic [19:0] act_a, act_b;

    always #5 clk = ~clk;

    index_counter_2d #(.ROWS(RA), .COLS(CA)) dut (
        .clk(clk), .rst(rst), .start(start), .count_en(count_en),
        .row_idx(row_idx), .col_idx(col_idx), .valid(valid), .row_end(row_end),
`ifdef IDXCNT_STALL_STAT_EN
        .done(done), .busy(busy), .stall_cnt(stall_cnt)
`else
        .done(done), .busy(busy)
`endif
    );
    index_counter_2d #(.ROWS(RB), .COLS(CB)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .count_en(count_en_b),
        .row_idx(row_b), .col_idx(col_b), .valid(valid_b), .row_end(row_end_b),
`ifdef IDXCNT_STALL_STAT_EN
        .done(done_b), .busy(busy_b), .stall_cnt(stall_b)
`else
        .done(done_b), .busy(busy_b)
`endif
    );

    assign act_a = {8'(row_idx), 8'(col_idx), valid, row_end, done, busy};
    assign act_b = {8'(row_b), 8'(col_b), valid_b, row_end_b, done_b, busy_b};

    // Reference: 0=idle, 1=run, 2=done; position is the linear row-major offset.
    function automatic logic [19:0] exp_a();
        int r = m_pos / CA, c = m_pos % CA;
        return {8'(r), 8'(c), m_st == 1, m_st == 1 && c == CA - 1, m_st == 2, m_st != 0};
    endfunction

    task automatic model_reset();
        m_st = 0; m_pos = 0; m_stall = 0;
    endtask

    task automatic model_step(input logic s, input logic e);
        if (m_st == 0 && s) begin m_st = 1; m_pos = 0; m_stall = 0; end
        else if (m_st == 1 && e) begin
            if (m_pos == RA * CA - 1) begin m_st = 2; m_pos = 0; end
            else m_pos++;
        end else if (m_st == 1) m_stall = (m_stall == 16'hFFFF) ? m_stall : m_stall + 1;
        else if (m_st == 2) m_st = 0;
    endtask

    task automatic step(input logic s, input logic e);
        start = s; count_en = e;
        @(posedge clk);
        model_step(s, e);
        #1;
    endtask

    task automatic step_b(input logic s, input logic e);
        start_b = s; count_en_b = e;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (act_a !== 20'h0) begin fails++; $display("FAIL reset_hold: got %h want %h", act_a, 20'h0); end
        @(negedge clk); rst = 0; model_reset();
        step(0, 0);
        checks++;
        if (act_a !== exp_a()) begin fails++; $display("FAIL reset_idle: got %h want %h", act_a, exp_a()); end
    endtask

    task automatic test_full_scan();
        int run_cycles = 0;
        step(1, 1);
        checks++;
        if (act_a !== exp_a()) begin fails++; $display("FAIL scan_first: got %h want %h", act_a, exp_a()); end
        run_cycles += int'(valid);
        for (int i = 2; i <= 27; i++) begin
            step(0, 1);
            run_cycles += int'(valid);
            checks++;
            if (act_a !== exp_a()) begin fails++; $display("FAIL scan c%0d: got %h want %h", i, act_a, exp_a()); end
            if (i == 26) begin
                checks++;
                if (done !== 1'b1) begin fails++; $display("FAIL scan_done: got %b want 1", done); end
            end
        end
        checks++;
        if (run_cycles != RA * CA) begin fails++; $display("FAIL scan_len: got %0d want %0d", run_cycles, RA * CA); end
    endtask

    task automatic test_stall();
        step(1, 1);
        for (int i = 0; i < 7; i++) step(0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0);
            checks++;
            if (act_a !== exp_a()) begin fails++; $display("FAIL stall c%0d: got %h want %h", i, act_a, exp_a()); end
        end
        checks++;
        if ({row_idx, col_idx, valid} !== {3'd1, 3'd2, 1'b1}) begin
            fails++; $display("FAIL stall_hold: got %0d,%0d v%b want 1,2 v1", row_idx, col_idx, valid);
        end
`ifdef IDXCNT_STALL_STAT_EN
        checks++;
        if (stall_cnt !== 16'd3) begin fails++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt); end
`endif
        for (int i = 0; i < 40 && m_st != 0; i++) begin
            step(0, 1);
            checks++;
            if (act_a !== exp_a()) begin fails++; $display("FAIL stall_drain c%0d: got %h want %h", i, act_a, exp_a()); end
        end
    endtask

    task automatic test_async_reset();
        step(1, 1);
        for (int i = 0; i < 13; i++) step(0, 1);
        checks++;
        if (act_a !== exp_a() || row_idx !== 3'd2 || col_idx !== 3'd3) begin
            fails++; $display("FAIL arst_pos: got %h want %h", act_a, exp_a());
        end
        #3 rst = 1;
        #1;
        model_reset();
        checks++;
        if (act_a !== 20'h0) begin fails++; $display("FAIL arst_now: got %h want %h", act_a, 20'h0); end
        @(posedge clk); @(negedge clk); rst = 0;
        step(1, 1);
        checks++;
        if (act_a !== exp_a() || !valid) begin fails++; $display("FAIL arst_restart: got %h want %h", act_a, exp_a()); end
        for (int i = 0; i < 30 && m_st != 0; i++) step(0, 1);
    endtask

    task automatic test_start_ignored();
        int dones = 0;
        step(1, 1);
        for (int i = 0; i < 16; i++) step(0, 1);
        step(1, 1);
        checks++;
        if (act_a !== exp_a()) begin fails++; $display("FAIL ign_run: got %h want %h", act_a, exp_a()); end
        for (int i = 0; i < 40 && m_st != 0; i++) begin
            step(m_st == 2, 1);
            dones += int'(done);
            checks++;
            if (act_a !== exp_a()) begin fails++; $display("FAIL ign c%0d: got %h want %h", i, act_a, exp_a()); end
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 1);
            checks++;
            if (act_a !== 20'h0) begin fails++; $display("FAIL ign_idle: got %h want %h", act_a, 20'h0); end
        end
        checks++;
        if (dones != 1) begin fails++; $display("FAIL ign_dones: got %0d want 1", dones); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
            checks++;
            if (act_a !== exp_a()) begin fails++; $display("FAIL rand c%0d: got %h want %h", i, act_a, exp_a()); end
`ifdef IDXCNT_STALL_STAT_EN
            checks++;
            if (stall_cnt !== 16'(m_stall)) begin fails++; $display("FAIL rand_stall c%0d: got %0d want %0d", i, stall_cnt, m_stall); end
`endif
        end
        for (int i = 0; i < 60 && m_st != 0; i++) step(0, 1);
    endtask

    task automatic test_3x7();
        int runs = 0, dones = 0, wraps = 0, pr = 0, pc = 0;
        logic [19:0] e;
        step_b(1, 1);
        for (int i = 1; i <= 23; i++) begin
            if (i > 1) step_b(0, 1);
            if (i <= RB * CB) e = {8'((i - 1) / CB), 8'((i - 1) % CB), 1'b1, (i - 1) % CB == CB - 1, 1'b0, 1'b1};
            else if (i == RB * CB + 1) e = 20'h3;
            else e = 20'h0;
            checks++;
            if (act_b !== e) begin fails++; $display("FAIL b37 c%0d: got %h want %h", i, act_b, e); end
            if (valid_b && i > 1 && pc == CB - 1 && int'(col_b) == 0 && int'(row_b) == pr + 1) wraps++;
            runs += int'(valid_b);
            dones += int'(done_b);
            pr = int'(row_b); pc = int'(col_b);
        end
        checks++;
        if (runs != 21 || dones != 1 || wraps != 2) begin
            fails++; $display("FAIL b37_tot: got run%0d done%0d wrap%0d want run21 done1 wrap2", runs, dones, wraps);
        end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_stall();
        test_async_reset();
        test_start_ignored();
        test_random();
        test_3x7();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end
endmodule

// File: doc/index_counter_2d.md
INDEX_COUNTER_2D -- requirements
Module: index_counter_2d

Interface
REQ-001 The block SHALL have parameter ROWS, default 5, meaning the number of rows scanned (>=2).
REQ-002 The block SHALL have parameter COLS, default 5, meaning the number of columns per row (>=2).
REQ-003 The block SHALL have parameter RW, default $clog2(ROWS), meaning the row index width.
REQ-004 The block SHALL have parameter CW, default $clog2(COLS), meaning the column index width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: scan request, honoured only in IDLE.
REQ-008 The block SHALL have port count_en, input, 1 bit: advance enable in RUN; 0 stalls the scan.
REQ-009 The block SHALL have port row_idx, output, RW bits: current row index.
REQ-010 The block SHALL have port col_idx, output, CW bits: current column index.
REQ-011 The block SHALL have port valid, output, 1 bit: high when the FSM is in RUN.
REQ-012 The block SHALL have port row_end, output, 1 bit: valid && col_idx==COLS-1.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse after the final element.
REQ-014 The block SHALL have port busy, output, 1 bit: high in RUN or DONE.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 In IDLE with start=1, the FSM SHALL enter RUN on the next edge with row_idx=0 and col_idx=0; count_en SHALL be ignored in that cycle.
REQ-017 In RUN with count_en=1 and col_idx<COLS-1, col_idx SHALL increment by 1 and row_idx SHALL hold.
REQ-018 In RUN with count_en=1 and col_idx==COLS-1 and row_idx<ROWS-1, col_idx SHALL wrap to 0 and row_idx SHALL increment by 1.
REQ-019 In RUN with count_en=1 at (ROWS-1, COLS-1), the FSM SHALL enter DONE and both indices SHALL clear to 0.
REQ-020 In RUN with count_en=0, both indices and the state SHALL hold.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE; done SHALL be 0 in every other state.
REQ-022 start SHALL be ignored in RUN and in DONE; a new scan SHALL require start in IDLE.
REQ-023 A full scan with count_en held at 1 SHALL take ROWS*COLS cycles in RUN, with done asserted in the following cycle.
REQ-024 Indices SHALL never exceed ROWS-1 or COLS-1 and SHALL not wrap through their full binary range.
REQ-025 row_end, valid, busy and done SHALL be decoded combinationally from registered state and indices, with no input-to-output combinational path.

Reset
REQ-026 While rst=1, the block SHALL immediately force IDLE with row_idx=0, col_idx=0, valid=0, row_end=0, done=0 and busy=0, including mid-scan.
REQ-027 After rst deasserts, the block SHALL accept start on the first rising edge.

Configuration
REQ-028 When macro IDXCNT_STALL_STAT_EN is defined, the block SHALL add output stall_cnt of 16 bits that clears on the IDLE->RUN transition, increments each RUN cycle with count_en=0, saturates at 16'hFFFF, holds otherwise, and resets to 0.
REQ-029 When IDXCNT_STALL_STAT_EN is undefined, the stall_cnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 The state encoding type (IDLE, RUN, DONE) and the stall counter width constant SHALL be placed in shared package idxcnt_pkg.
REQ-031 Each index SHALL be produced by one instance of sub-module mod_counter (parameters MOD and W; ports clk, rst, clr, en, q, tc), with the column counter's tc gating the row counter's en.

Verification
REQ-032 Reset, then start=1 for one cycle with count_en=1 constant (ROWS=COLS=5) -> (row,col) sequence (0,0)..(4,4) over 25 cycles, row_end high on col=4, done high on cycle 26, busy low on cycle 27.
REQ-033 In RUN at (1,2), count_en=0 for 3 cycles -> indices hold at (1,2) and valid stays 1; with IDXCNT_STALL_STAT_EN defined, stall_cnt=3.
REQ-034 At (2,3), assert rst asynchronously between edges -> outputs go to 0 and state goes to IDLE before the next edge; the next start begins at (0,0).
REQ-035 Assert start at (3,1) and during the DONE cycle -> no restart occurs; the scan completes normally and the block returns to IDLE.
REQ-036 With ROWS=3 and COLS=7 -> 21 RUN cycles, col wraps 6->0 with row increment, and a single done pulse.
